block_write_buffer: RTL and testbench

- Write-combining buffer between the CPU data-store path and block-organised memory.
- Gathers WORD_W-bit stores into one BLOCK_W-bit collect entry with a per-word valid mask.
- Hands completed or evicted blocks to a single outbound register that drives a req/ack block-write port into memory.
- Acts as the writer on the memory's block interface; the instruction cache acts as the reader.

---
 rtl/block_write_buffer_pkg.sv | 24 ++
 rtl/block_write_buffer_if.sv | 35 +++
 rtl/block_write_buffer_wbuf_timer.sv | 52 +++++
 rtl/block_write_buffer.sv | 174 +++++++++++++++++
 tb/tb_block_write_buffer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_write_buffer_pkg.sv
// Shared constants and state encodings for the block write buffer slice.
// Block geometry defaults and the collect/outbound entry states.
package block_write_buffer_pkg;

    localparam int WORD_W_DEF  = 32;
    localparam int BLOCK_W_DEF = 1024;
    localparam int ADDR_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    localparam int WPB         = BLOCK_W_DEF / WORD_W_DEF;
    localparam int BLOCK_OFF_W = $clog2(WPB);

    typedef enum logic [1:0] {
        COL_EMPTY = 2'd0,
        COL_OPEN  = 2'd1,
        COL_FULL  = 2'd2
    } col_state_e;

    typedef enum logic {
        OUT_FREE = 1'b0,
        OUT_BUSY = 1'b1
    } out_state_e;

endpackage

// File: rtl/block_write_buffer_if.sv
// Store port and memory block-write port of the write buffer.
// The slave modport is the buffer itself; the master side is CPU plus memory.
interface block_write_buffer_if
    import block_write_buffer_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) ();

    localparam int NWORDS = BLOCK_W / WORD_W;

    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data;
    logic                flush;
    logic                idle;
    logic                mem_req;
    logic                mem_ack;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BLOCK_W-1:0]  mem_block;
    logic [NWORDS-1:0]   mem_mask;

    modport slave (
        input  wr_valid, wr_addr, wr_data, flush, mem_ack,
        output wr_ready, idle, mem_req, mem_addr, mem_block, mem_mask
    );

    modport master (
        output wr_valid, wr_addr, wr_data, flush, mem_ack,
        input  wr_ready, idle, mem_req, mem_addr, mem_block, mem_mask
    );

endinterface

// File: rtl/block_write_buffer_wbuf_timer.sv
// Saturating idle counter for the open collect entry; expired is registered
// and rises on the edge where the count reaches TIMEOUT (never when TIMEOUT is 0).
module wbuf_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             expired_r;
    logic             expired_s;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        count_s   = count_r;
        expired_s = 1'b0;
        if (clr) begin
            count_s = {CNT_W{1'b0}};
        end else if (en && (count_r != LIMIT)) begin
            count_s = count_r + CNT_W'(1);
        end else begin
            count_s = count_r;
        end
        if (TIMEOUT != 0) begin
            expired_s = (count_s == LIMIT);
        end else begin
            expired_s = 1'b0;
        end
    end

    // Counter and expiry flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= {CNT_W{1'b0}};
            expired_r <= 1'b0;
        end else begin
            count_r   <= count_s;
            expired_r <= expired_s;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/block_write_buffer.sv
// Write-combining buffer: gathers word stores into one collect block and hands
// completed or evicted blocks to a single outbound register on a req/ack port.
module block_write_buffer
    import block_write_buffer_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    block_write_buffer_if.slave bus
);

    localparam int NWORDS = BLOCK_W / WORD_W;
    localparam int OFF_W  = $clog2(NWORDS);
    localparam int TAG_W  = ADDR_W - OFF_W;

    col_state_e          col_state_r, col_state_s;
    out_state_e          out_state_r, out_state_s;
    logic [TAG_W-1:0]    col_tag_r, col_tag_s;
    logic [BLOCK_W-1:0]  col_data_r, col_data_s;
    logic [NWORDS-1:0]   col_mask_r, col_mask_s;
    logic [ADDR_W-1:0]   out_addr_r, out_addr_s;
    logic [BLOCK_W-1:0]  out_data_r, out_data_s;
    logic [NWORDS-1:0]   out_mask_r, out_mask_s;
    logic                flush_pend_r, flush_pend_s;
    logic                idle_r, idle_s;

    logic [TAG_W-1:0]    wr_tag_s;
    logic [OFF_W-1:0]    wr_idx_s;
    logic [BLOCK_W-1:0]  wr_word_s;
    logic [BLOCK_W-1:0]  wr_wmask_s;
    logic [NWORDS-1:0]   wr_bit_s;
    logic [BLOCK_W-1:0]  merge_data_s;
    logic [NWORDS-1:0]   merge_mask_s;
    logic                col_valid_s, out_busy_s, out_avail_s, same_blk_s, diff_wr_s;
    logic                expired_s, evict_need_s, evict_s, wr_ready_s, wr_fire_s, timer_clr_s;

    assign wr_tag_s   = bus.wr_addr[ADDR_W-1:OFF_W];
    assign wr_idx_s   = bus.wr_addr[OFF_W-1:0];
    assign wr_word_s  = {{(BLOCK_W-WORD_W){1'b0}}, bus.wr_data} << (wr_idx_s * WORD_W);
    assign wr_wmask_s = {{(BLOCK_W-WORD_W){1'b0}}, {WORD_W{1'b1}}} << (wr_idx_s * WORD_W);
    assign wr_bit_s   = {{(NWORDS-1){1'b0}}, 1'b1} << wr_idx_s;

    assign merge_data_s = (col_data_r & ~wr_wmask_s) | wr_word_s;
    assign merge_mask_s = col_mask_r | wr_bit_s;

    assign col_valid_s  = (col_state_r != COL_EMPTY);
    assign out_busy_s   = (out_state_r == OUT_BUSY);
    assign out_avail_s  = !out_busy_s || bus.mem_ack;
    assign same_blk_s   = col_valid_s && (col_tag_r == wr_tag_s);
    assign diff_wr_s    = bus.wr_valid && col_valid_s && !same_blk_s;
    assign evict_need_s = col_valid_s && ((col_state_r == COL_FULL) || expired_s ||
                                          flush_pend_r || diff_wr_s);
    assign evict_s      = evict_need_s && out_avail_s;
    // A store stalls only while the collect entry has nowhere to go.
    assign wr_ready_s   = !(evict_need_s && !out_avail_s);
    assign wr_fire_s    = bus.wr_valid && wr_ready_s;
    assign timer_clr_s  = wr_fire_s || !col_valid_s || evict_s;

    wbuf_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr_s),
        .en      (col_valid_s),
        .expired (expired_s)
    );

    // Collect entry: open on a new block, empty on hand-off, merge same-block stores
    always_comb begin
        col_tag_s  = col_tag_r;
        col_data_s = col_data_r;
        col_mask_s = col_mask_r;
        if (wr_fire_s && !same_blk_s) begin
            col_tag_s  = wr_tag_s;
            col_data_s = wr_word_s;
            col_mask_s = wr_bit_s;
        end else if (evict_s) begin
            col_tag_s  = {TAG_W{1'b0}};
            col_data_s = {BLOCK_W{1'b0}};
            col_mask_s = {NWORDS{1'b0}};
        end else if (wr_fire_s) begin
            col_data_s = merge_data_s;
            col_mask_s = merge_mask_s;
        end else begin
            col_tag_s  = col_tag_r;
        end
    end

    // Outbound register: load on eviction (with a same-block store merged in), clear on ack
    always_comb begin
        out_addr_s = out_addr_r;
        out_data_s = out_data_r;
        out_mask_s = out_mask_r;
        if (evict_s) begin
            out_addr_s = {col_tag_r, {OFF_W{1'b0}}};
            if (wr_fire_s && same_blk_s) begin
                out_data_s = merge_data_s;
                out_mask_s = merge_mask_s;
            end else begin
                out_data_s = col_data_r;
                out_mask_s = col_mask_r;
            end
        end else if (out_busy_s && bus.mem_ack) begin
            out_addr_s = {ADDR_W{1'b0}};
            out_data_s = {BLOCK_W{1'b0}};
            out_mask_s = {NWORDS{1'b0}};
        end else begin
            out_addr_s = out_addr_r;
        end
    end

    // Entry state transitions, flush tracking and idle
    always_comb begin
        col_state_s  = COL_EMPTY;
        out_state_s  = out_state_r;
        flush_pend_s = 1'b0;
        idle_s       = 1'b0;
        if (col_mask_s == {NWORDS{1'b1}}) begin
            col_state_s = COL_FULL;
        end else if (col_mask_s != {NWORDS{1'b0}}) begin
            col_state_s = COL_OPEN;
        end else begin
            col_state_s = COL_EMPTY;
        end
        case (out_state_r)
            OUT_FREE: out_state_s = evict_s ? OUT_BUSY : OUT_FREE;
            OUT_BUSY: out_state_s = (evict_s || !bus.mem_ack) ? OUT_BUSY : OUT_FREE;
            default:  out_state_s = OUT_FREE;
        endcase
        // Pending flush persists until the collect entry is finally empty.
        flush_pend_s = (flush_pend_r || (bus.flush && col_valid_s)) && (col_state_s != COL_EMPTY);
        idle_s       = (col_state_s == COL_EMPTY) && (out_state_s == OUT_FREE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_state_r  <= COL_EMPTY;
            out_state_r  <= OUT_FREE;
            col_tag_r    <= {TAG_W{1'b0}};
            col_data_r   <= {BLOCK_W{1'b0}};
            col_mask_r   <= {NWORDS{1'b0}};
            out_addr_r   <= {ADDR_W{1'b0}};
            out_data_r   <= {BLOCK_W{1'b0}};
            out_mask_r   <= {NWORDS{1'b0}};
            flush_pend_r <= 1'b0;
            idle_r       <= 1'b1;
        end else begin
            col_state_r  <= col_state_s;
            out_state_r  <= out_state_s;
            col_tag_r    <= col_tag_s;
            col_data_r   <= col_data_s;
            col_mask_r   <= col_mask_s;
            out_addr_r   <= out_addr_s;
            out_data_r   <= out_data_s;
            out_mask_r   <= out_mask_s;
            flush_pend_r <= flush_pend_s;
            idle_r       <= idle_s;
        end
    end

    assign bus.wr_ready  = wr_ready_s;
    assign bus.idle      = idle_r;
    assign bus.mem_req   = out_busy_s;
    assign bus.mem_addr  = out_addr_r;
    assign bus.mem_block = out_data_r;
    assign bus.mem_mask  = out_mask_r;

endmodule

// File: tb/tb_block_write_buffer.sv
// Self-checking bench for block_write_buffer: directed vector table, hand-written
// corner sequences, and randomized traffic against a word-array reference model.
module tb_block_write_buffer;
    import block_write_buffer_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int NW      = 32;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    block_write_buffer_if bus ();

    block_write_buffer #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one collect entry and one outbound entry as word arrays.
    bit          m_col_valid;
    logic [26:0] m_col_tag;
    logic [31:0] m_col_words [NW];
    logic [31:0] m_col_mask;
    int          m_timer;
    bit          m_fp;
    bit          m_out_valid;
    logic [31:0] m_out_addr;
    logic [31:0] m_out_words [NW];
    logic [31:0] m_out_mask;

    typedef struct {
        logic        wv;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fl;
        logic        ack;
        logic        e_ready;
        logic        e_req;
        logic        e_idle;
        logic [31:0] e_addr;
        logic [31:0] e_mask;
        logic [31:0] e_w0;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_col_valid = 1'b0; m_col_tag = '0; m_col_mask = '0; m_timer = 0; m_fp = 1'b0;
        m_out_valid = 1'b0; m_out_addr = '0; m_out_mask = '0;
        for (int i = 0; i < NW; i++) begin
            m_col_words[i] = '0;
            m_out_words[i] = '0;
        end
    endtask

    function automatic bit m_need();
        bit diff;
        diff = bus.wr_valid && (bus.wr_addr[31:5] != m_col_tag);
        return m_col_valid && ((m_col_mask == 32'hFFFF_FFFF) ||
               ((TIMEOUT != 0) && (m_timer == TIMEOUT)) || m_fp || diff);
    endfunction

    function automatic logic [1023:0] m_block();
        logic [1023:0] b;
        b = '0;
        for (int i = 0; i < NW; i++)
            if (m_out_mask[i]) b[i*32 +: 32] = m_out_words[i];
        return b;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_update();
        bit need, avail, fire, evict, same, colv0;
        int idx;
        logic [26:0] tag;
        tag   = bus.wr_addr[31:5];
        idx   = int'(bus.wr_addr[4:0]);
        same  = m_col_valid && (tag == m_col_tag);
        need  = m_need();
        avail = !m_out_valid || bus.mem_ack;
        fire  = bus.wr_valid && !(need && !avail);
        evict = need && avail;
        colv0 = m_col_valid;
        if (m_out_valid && bus.mem_ack) m_out_valid = 1'b0;
        if (evict) begin
            m_out_valid = 1'b1;
            m_out_addr  = {m_col_tag, 5'd0};
            m_out_mask  = m_col_mask;
            for (int i = 0; i < NW; i++) m_out_words[i] = m_col_words[i];
            if (fire && same) begin
                m_out_words[idx] = bus.wr_data;
                m_out_mask[idx]  = 1'b1;
            end
            m_col_valid = 1'b0;
        end
        if (fire && !(evict && same)) begin
            if (!m_col_valid) begin
                m_col_valid = 1'b1;
                m_col_tag   = tag;
                m_col_mask  = '0;
                for (int i = 0; i < NW; i++) m_col_words[i] = '0;
            end
            m_col_words[idx] = bus.wr_data;
            m_col_mask[idx]  = 1'b1;
        end
        if (bus.flush && colv0) m_fp = 1'b1;
        if (!m_col_valid) m_fp = 1'b0;
        if (fire || !colv0 || evict) m_timer = 0;
        else if (m_timer < TIMEOUT) m_timer++;
    endtask

    task automatic check_model(input string tag);
        bit exp_ready;
        exp_ready = !(m_need() && m_out_valid && !bus.mem_ack);
        chk({tag, "_ready"}, bus.wr_ready, exp_ready);
        chk({tag, "_req"}, bus.mem_req, m_out_valid);
        chk({tag, "_idle"}, bus.idle, !m_col_valid && !m_out_valid);
        if (m_out_valid) begin
            chk({tag, "_addr"}, bus.mem_addr, m_out_addr);
            chk({tag, "_mask"}, bus.mem_mask, m_out_mask);
            chk({tag, "_block"}, bus.mem_block, m_block());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_in(input logic wv, input logic [31:0] a, input logic [31:0] d,
                          input logic fl, input logic ack);
        bus.wr_valid = wv; bus.wr_addr = a; bus.wr_data = d; bus.flush = fl; bus.mem_ack = ack;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        #1;
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_idle", bus.idle, 1'b1);
        chk("rst_ready", bus.wr_ready, 1'b1);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_mask", bus.mem_mask, 32'h0);
        chk("rst_block", bus.mem_block, 1024'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1023:0] exp_blk;
        int lat;
        int pwr;
        int tg;
        int ix;

        // wv addr data fl ack | ready req idle addr mask w0
        tbl[0]  = '{1'b1, 32'h100, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h0, 32'h0};
        tbl[1]  = '{1'b1, 32'h200, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0};
        tbl[2]  = '{1'b1, 32'h300, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h1, 32'hA};
        tbl[3]  = '{1'b1, 32'h300, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h1, 32'hA};
        tbl[4]  = '{1'b1, 32'h300, 32'hC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h1, 32'hA};
        tbl[5]  = '{1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h1, 32'hB};
        tbl[6]  = '{1'b0, 32'h0,   32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h1, 32'hB};
        tbl[7]  = '{1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h1, 32'hC};
        tbl[10] = '{1'b0, 32'h0,   32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h1, 32'hC};
        tbl[11] = '{1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h0, 32'h0};

        do_reset();

        // Directed vector table: switch blocks, stall on busy outbound, flush.
        for (int r = 0; r < 12; r++) begin
            set_in(tbl[r].wv, tbl[r].addr, tbl[r].data, tbl[r].fl, tbl[r].ack);
            #1;
            chk($sformatf("tbl%0d_ready", r), bus.wr_ready, tbl[r].e_ready);
            chk($sformatf("tbl%0d_req", r), bus.mem_req, tbl[r].e_req);
            chk($sformatf("tbl%0d_idle", r), bus.idle, tbl[r].e_idle);
            if (tbl[r].e_req) begin
                chk($sformatf("tbl%0d_addr", r), bus.mem_addr, tbl[r].e_addr);
                chk($sformatf("tbl%0d_mask", r), bus.mem_mask, tbl[r].e_mask);
                chk($sformatf("tbl%0d_w0", r), bus.mem_block[31:0], tbl[r].e_w0);
            end
            tick();
        end

        // Full block: 32 consecutive stores, evicted on the following edge.
        for (int i = 0; i < NW; i++) begin
            set_in(1'b1, 32'h40 + i, 32'h40 + i, 1'b0, 1'b0);
            #1;
            chk("full_store_ready", bus.wr_ready, 1'b1);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        exp_blk = '0;
        for (int i = 0; i < NW; i++) exp_blk[i*32 +: 32] = 32'h40 + i;
        chk("full_req", bus.mem_req, 1'b1);
        chk("full_addr", bus.mem_addr, 32'h40);
        chk("full_mask", bus.mem_mask, 32'hFFFF_FFFF);
        chk("full_block", bus.mem_block, exp_blk);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("full_idle", bus.idle, 1'b1);
        chk("full_req_drop", bus.mem_req, 1'b0);

        // Timeout eviction of a partial block.
        set_in(1'b1, 32'h100, 32'h11, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h103, 32'h33, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        lat = 0;
        while (!bus.mem_req && lat < 40) begin
            tick();
            lat++;
        end
        chk("timeout_latency", lat, TIMEOUT + 1);
        exp_blk = '0;
        exp_blk[31:0]   = 32'h11;
        exp_blk[127:96] = 32'h33;
        chk("timeout_mask", bus.mem_mask, 32'h9);
        chk("timeout_addr", bus.mem_addr, 32'h100);
        chk("timeout_block", bus.mem_block, exp_blk);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;

        // Flush of a single word, ack withheld for three cycles.
        set_in(1'b1, 32'h7, 32'h77, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        bus.flush = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("flush_req", bus.mem_req, 1'b1);
            chk("flush_mask", bus.mem_mask, 32'h80);
            chk("flush_addr", bus.mem_addr, 32'h0);
            chk("flush_word7", bus.mem_block[255:224], 32'h77);
            tick();
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("flush_idle", bus.idle, 1'b1);

        // Asynchronous reset while a block write is pending.
        set_in(1'b1, 32'h20, 32'h5, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        bus.flush = 1'b0;
        tick();
        chk("arst_pre_req", bus.mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", bus.mem_req, 1'b0);
        chk("arst_idle", bus.idle, 1'b1);
        chk("arst_ready", bus.wr_ready, 1'b1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic in segments of varying store density.
        for (int seg = 0; seg < 12; seg++) begin
            pwr = (seg % 3 == 0) ? 85 : ((seg % 3 == 1) ? 40 : 3);
            for (int c = 0; c < 250; c++) begin
                if (seg % 4 == 0) begin
                    tg = ($urandom_range(99) < 90) ? 0 : 1;
                    ix = c % 32;
                end else begin
                    tg = $urandom_range(2);
                    ix = $urandom_range(31);
                end
                set_in($urandom_range(99) < pwr, 32'h400 + tg * 32 + ix, $urandom,
                       $urandom_range(99) < 2, $urandom_range(99) < 35);
                #1;
                check_model("rnd");
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
